// File: rtl/fake_mario_nios2_gen2_0_cpu_trace_capture.sv
// Circular on-chip trace buffer: captures trace words while tracing is
// enabled and serves registered read-back to the debug slave.
module fake_mario_nios2_gen2_0_cpu_trace_capture #(
  parameter int DEPTH_LOG2   = 7,
  parameter int WIDTH        = 36,
  parameter int STOP_ON_FULL = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  trc_in_valid,
  input  logic [WIDTH-1:0]      trc_in_data,
  input  logic [37:0]           jdo,
  input  logic                  take_action_tracectrl,
  input  logic                  take_action_tracemem_a,
  input  logic                  take_action_tracemem_b,
  output logic                  trc_on,
  output logic                  tracemem_on,
  output logic [DEPTH_LOG2-1:0] trc_im_addr,
  output logic                  trc_wrap,
  output logic [WIDTH-1:0]      tracemem_trcdata,
  output logic                  tracemem_tw
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic                  trc_on_q, trc_on_d;
  logic [DEPTH_LOG2-1:0] wr_addr_q, wr_addr_d;
  logic                  wrap_q, wrap_d;
  logic [DEPTH_LOG2-1:0] rd_addr_q, rd_addr_d;
  logic [WIDTH-1:0]      rd_data_q;
  logic                  tw_q;
  logic [WIDTH-1:0]      mem [DEPTH];

  logic clear, capture, last_slot, rd_valid;

  // Only the low pointer bits and the two control bits of jdo are meaningful here.
  logic unused_jdo;
  assign unused_jdo = ^jdo[37:DEPTH_LOG2];

  // A clear in the same cycle as a capture drops the write.
  assign clear     = take_action_tracectrl & jdo[0];
  assign capture   = trc_on_q & trc_in_valid & ~clear;
  assign last_slot = &wr_addr_q;
  // Validity uses the pre-update pointers, so a read alongside a clear sees old state.
  assign rd_valid  = wrap_q | (rd_addr_q < wr_addr_q);

  // Next-state for trace control, write pointer, wrap flag and read pointer.
  always_comb begin
    trc_on_d  = trc_on_q;
    wr_addr_d = wr_addr_q;
    wrap_d    = wrap_q;
    rd_addr_d = rd_addr_q;
    if (capture) begin
      wr_addr_d = wr_addr_q + 1'b1;
      if (last_slot) begin
        wrap_d = 1'b1;
        if (STOP_ON_FULL != 0) trc_on_d = 1'b0;
      end
    end
    if (take_action_tracectrl) begin
      trc_on_d = jdo[1];
      if (jdo[0]) begin
        wr_addr_d = '0;
        wrap_d    = 1'b0;
      end
    end
    if (take_action_tracemem_b) rd_addr_d = rd_addr_q + 1'b1;
    // A pointer load overrides the post-read increment.
    if (take_action_tracemem_a) rd_addr_d = jdo[DEPTH_LOG2-1:0];
  end

  // Control and pointer registers, plus the registered read-back word.
  always_ff @(posedge clk) begin
    if (reset) begin
      trc_on_q  <= 1'b0;
      wr_addr_q <= '0;
      wrap_q    <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      tw_q      <= 1'b0;
    end else begin
      trc_on_q  <= trc_on_d;
      wr_addr_q <= wr_addr_d;
      wrap_q    <= wrap_d;
      rd_addr_q <= rd_addr_d;
      if (take_action_tracemem_b) begin
        rd_data_q <= mem[rd_addr_q];
        tw_q      <= rd_valid;
      end
    end
  end

  // Trace RAM write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (!reset && capture) mem[wr_addr_q] <= trc_in_data;
  end

  assign trc_on           = trc_on_q;
  assign tracemem_on      = trc_on_q;
  assign trc_im_addr      = wr_addr_q;
  assign trc_wrap         = wrap_q;
  assign tracemem_trcdata = rd_data_q;
  assign tracemem_tw      = tw_q;

endmodule

// File: tb/tb_fake_mario_nios2_gen2_0_cpu_trace_capture.sv
// Bench for the trace capture buffer: an overwrite-mode and a stop-on-full
// instance share stimulus and are checked each cycle against a model.
module tb_fake_mario_nios2_gen2_0_cpu_trace_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        trc_in_valid = 1'b0;
  logic [35:0] trc_in_data = '0;
  logic [37:0] jdo = '0;
  logic        ctrl = 1'b0, tm_a = 1'b0, tm_b = 1'b0;

  logic        o_on [2];
  logic        o_mon [2];
  logic [6:0]  o_addr [2];
  logic        o_wrap [2];
  logic [35:0] o_data [2];
  logic        o_tw [2];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fake_mario_nios2_gen2_0_cpu_trace_capture #(.DEPTH_LOG2(7), .WIDTH(36), .STOP_ON_FULL(0)) u0 (
    .clk(clk), .reset(reset), .trc_in_valid(trc_in_valid), .trc_in_data(trc_in_data), .jdo(jdo),
    .take_action_tracectrl(ctrl), .take_action_tracemem_a(tm_a), .take_action_tracemem_b(tm_b),
    .trc_on(o_on[0]), .tracemem_on(o_mon[0]), .trc_im_addr(o_addr[0]), .trc_wrap(o_wrap[0]),
    .tracemem_trcdata(o_data[0]), .tracemem_tw(o_tw[0]));

  fake_mario_nios2_gen2_0_cpu_trace_capture #(.DEPTH_LOG2(7), .WIDTH(36), .STOP_ON_FULL(1)) u1 (
    .clk(clk), .reset(reset), .trc_in_valid(trc_in_valid), .trc_in_data(trc_in_data), .jdo(jdo),
    .take_action_tracectrl(ctrl), .take_action_tracemem_a(tm_a), .take_action_tracemem_b(tm_b),
    .trc_on(o_on[1]), .tracemem_on(o_mon[1]), .trc_im_addr(o_addr[1]), .trc_wrap(o_wrap[1]),
    .tracemem_trcdata(o_data[1]), .tracemem_tw(o_tw[1]));

  // Model state: the buffer as a plain array plus a count-style write index.
  bit          m_on [2];
  int          m_addr [2];
  bit          m_wrap [2];
  int          m_rd [2];
  logic [35:0] m_data [2];
  bit          m_tw [2];
  bit          m_known [2];
  logic [35:0] m_mem [2][128];
  bit          m_wr [2][128];

  always @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (reset) begin
        m_on[s] = 0; m_addr[s] = 0; m_wrap[s] = 0; m_rd[s] = 0;
        m_data[s] = '0; m_tw[s] = 0; m_known[s] = 1;
      end else begin
        int nrd;
        bit cap;
        nrd = m_rd[s];
        if (tm_b) begin
          m_data[s]  = m_mem[s][m_rd[s]];
          m_known[s] = m_wr[s][m_rd[s]];
          m_tw[s]    = m_wrap[s] || (m_rd[s] < m_addr[s]);
          nrd = (m_rd[s] + 1) % 128;
        end
        if (tm_a) nrd = int'(jdo[6:0]);
        m_rd[s] = nrd;
        cap = m_on[s] && trc_in_valid && !(ctrl && jdo[0]);
        if (cap) begin
          m_mem[s][m_addr[s]] = trc_in_data;
          m_wr[s][m_addr[s]]  = 1;
          if (m_addr[s] == 127) begin
            m_wrap[s] = 1;
            if (s == 1) m_on[s] = 0;
          end
          m_addr[s] = (m_addr[s] + 1) % 128;
        end
        if (ctrl) begin
          if (jdo[0]) begin m_addr[s] = 0; m_wrap[s] = 0; end
          m_on[s] = jdo[1];
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  task automatic cmp_model();
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("u%0d.trc_on", s),      64'(o_on[s]),   64'(m_on[s]));
      chk($sformatf("u%0d.tracemem_on", s), 64'(o_mon[s]),  64'(m_on[s]));
      chk($sformatf("u%0d.trc_im_addr", s), 64'(o_addr[s]), 64'(m_addr[s]));
      chk($sformatf("u%0d.trc_wrap", s),    64'(o_wrap[s]), 64'(m_wrap[s]));
      chk($sformatf("u%0d.tracemem_tw", s), 64'(o_tw[s]),   64'(m_tw[s]));
      if (m_known[s])
        chk($sformatf("u%0d.trcdata", s), 64'(o_data[s]), 64'(m_data[s]));
    end
  endtask

  // Advance one clock, then compare away from the edge and drop the strobes.
  task automatic tick();
    @(posedge clk);
    #2;
    cmp_model();
    ctrl = 1'b0; tm_a = 1'b0; tm_b = 1'b0;
  endtask

  initial begin
    // Reset and idle
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst.on", 64'(o_on[0]), 0);
    chk("rst.addr", 64'(o_addr[0]), 0);
    chk("rst.data", 64'(o_data[1]), 0);
    trc_in_valid = 1'b1;
    for (int i = 0; i < 128; i++) begin trc_in_data = 36'($urandom); tick(); end
    trc_in_valid = 1'b0;
    chk("idle.addr", 64'(o_addr[0]), 0);
    chk("idle.wrap", 64'(o_wrap[1]), 0);

    // Enable, capture five words, read back
    ctrl = 1'b1; jdo = 38'h3; tick();
    chk("en.on", 64'(o_on[0]), 1);
    trc_in_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin trc_in_data = 36'(i); tick(); end
    trc_in_valid = 1'b0;
    chk("cap5.addr", 64'(o_addr[0]), 5);
    tm_a = 1'b1; jdo = 38'h0; tick();
    for (int i = 1; i <= 5; i++) begin
      tm_b = 1'b1; tick();
      chk($sformatf("rd%0d.data", i - 1), 64'(o_data[0]), 64'(i));
      chk($sformatf("rd%0d.tw", i - 1), 64'(o_tw[0]), 1);
    end
    tm_b = 1'b1; tick();
    chk("rd5.tw", 64'(o_tw[0]), 0);

    // Wrap: 130 captures of index data
    ctrl = 1'b1; jdo = 38'h3; tick();
    trc_in_valid = 1'b1;
    for (int i = 0; i < 130; i++) begin
      trc_in_data = 36'(i); tick();
      if (i == 127) begin
        chk("wrap0.wrap", 64'(o_wrap[0]), 1);
        chk("wrap1.on", 64'(o_on[1]), 0);
        chk("wrap1.addr", 64'(o_addr[1]), 0);
      end
    end
    trc_in_valid = 1'b0;
    chk("wrap0.addr", 64'(o_addr[0]), 2);
    chk("wrap1.addr_end", 64'(o_addr[1]), 0);
    tm_a = 1'b1; jdo = 38'h0; tick();
    tm_b = 1'b1; tick();
    chk("wrap0.rd0", 64'(o_data[0]), 128);
    chk("wrap1.rd0", 64'(o_data[1]), 0);
    chk("wrap1.rd0.tw", 64'(o_tw[1]), 1);
    tm_a = 1'b1; jdo = 38'h2; tick();
    tm_b = 1'b1; tick();
    chk("wrap0.rd2", 64'(o_data[0]), 2);
    chk("wrap0.rd2.tw", 64'(o_tw[0]), 1);
    // Load and read together: read uses old pointer (3), load wins (10)
    tm_a = 1'b1; tm_b = 1'b1; jdo = 38'd10; tick();
    chk("ab.data", 64'(o_data[0]), 3);
    tm_b = 1'b1; tick();
    chk("ab.next", 64'(o_data[0]), 10);

    // Clear together with a capture at address 9
    ctrl = 1'b1; jdo = 38'h3; tick();
    trc_in_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin trc_in_data = 36'h100 + 36'(i); tick(); end
    ctrl = 1'b1; jdo = 38'h3; trc_in_data = 36'hABC; tick();
    trc_in_valid = 1'b0;
    chk("clrcap.addr", 64'(o_addr[0]), 0);
    chk("clrcap.wrap", 64'(o_wrap[0]), 0);
    tm_a = 1'b1; jdo = 38'd9; tick();
    tm_b = 1'b1; tick();
    chk("clrcap.rd9", 64'(o_data[0]), 9);
    chk("clrcap.tw", 64'(o_tw[0]), 0);

    // Read in the same cycle as a clear uses pre-clear pointers
    trc_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin trc_in_data = 36'h200 + 36'(i); tick(); end
    trc_in_valid = 1'b0;
    tm_a = 1'b1; jdo = 38'h0; tick();
    tm_b = 1'b1; ctrl = 1'b1; jdo = 38'h3; tick();
    chk("rdclr.data", 64'(o_data[0]), 36'h200);
    chk("rdclr.tw", 64'(o_tw[0]), 1);
    chk("rdclr.addr", 64'(o_addr[0]), 0);

    // Read and write to the same address: old contents returned
    tm_a = 1'b1; jdo = 38'h0; tick();
    tm_b = 1'b1; trc_in_valid = 1'b1; trc_in_data = 36'h55; tick();
    chk("rw.data", 64'(o_data[0]), 36'h200);
    // Tracing turned off in the same cycle as a word: still captured
    ctrl = 1'b1; jdo = 38'h0; trc_in_data = 36'h77; tick();
    trc_in_valid = 1'b0;
    chk("off.addr", 64'(o_addr[0]), 2);
    chk("off.on", 64'(o_on[0]), 0);

    // Reset during streaming capture at address 40
    ctrl = 1'b1; jdo = 38'h3; tick();
    trc_in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin trc_in_data = 36'h300 + 36'(i); tick(); end
    chk("mid.addr", 64'(o_addr[0]), 40);
    reset = 1'b1; trc_in_data = 36'hDEAD; tick();
    reset = 1'b0; trc_in_valid = 1'b0;
    chk("mid.on", 64'(o_on[0]), 0);
    chk("mid.addr0", 64'(o_addr[0]), 0);
    tm_b = 1'b1; tick();
    chk("mid.tw", 64'(o_tw[0]), 0);
    tm_a = 1'b1; jdo = 38'd40; tick();
    tm_b = 1'b1; tick();
    chk("mid.rd40", 64'(o_data[0]), 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fake_mario_nios2_gen2_0_cpu_trace_capture.md
# fake_mario_nios2_gen2_0_cpu_trace_capture

Circular on-chip trace buffer for the Nios II debug path. It captures 36-bit trace words from the CPU trace packer into a 128-entry RAM while tracing is enabled. It serves registered read-back to the debug slave. It sits directly upstream of the debug slave and produces that stage's `trc_on`, `trc_im_addr`, `trc_wrap`, `tracemem_on`, `tracemem_trcdata` and `tracemem_tw` inputs. Its trace control and read commands come from the debug slave's `jdo` and `take_action_*` strobes.

## Interface
- `DEPTH_LOG2`, 7, log2 of buffer entries (128).
- `WIDTH`, 36, trace word width.
- `STOP_ON_FULL`, 0, 1 = stop tracing on wrap instead of overwriting.

- `clk`  in  1  sole clock; everything is in this domain.
- `reset`  in  1  synchronous, active-high reset.
- `trc_in_valid`  in  1  trace word present this cycle.
- `trc_in_data`  in  36  trace word.
- `jdo`  in  38  debug command data from the debug slave.
- `take_action_tracectrl`  in  1  one-cycle strobe: apply trace control from `jdo`.
- `take_action_tracemem_a`  in  1  one-cycle strobe: load the read pointer from `jdo[6:0]`.
- `take_action_tracemem_b`  in  1  one-cycle strobe: read the entry at the read pointer, then advance the read pointer.
- `trc_on`  out  1  capture enabled.
- `tracemem_on`  out  1  equals `trc_on`.
- `trc_im_addr`  out  7  next write address.
- `trc_wrap`  out  1  buffer has wrapped at least once since the last clear.
- `tracemem_trcdata`  out  36  last read-back word.
- `tracemem_tw`  out  1  `tracemem_trcdata` holds a word written since the last clear.

## Operation
- **Trace control.** On `take_action_tracectrl`:
  - `jdo[0]`=1 is a clear: `trc_im_addr`←0 and `trc_wrap`←0.
  - `jdo[1]` is the new `trc_on` value.
  - Both fields apply in the same cycle.
- **Capture.**
  - Condition: `trc_on` (registered value) & `trc_in_valid`.
  - On capture: `mem[trc_im_addr]`←`trc_in_data` and `trc_im_addr`←`trc_im_addr`+1, mod 128.
- **Wrap.**
  - A capture at address 127 sets `trc_wrap`←1. The bit is sticky until the next clear or reset.
  - With `STOP_ON_FULL`=1, that same capture also clears `trc_on`. The address wraps to 0 and no further writes occur.
- **Read pointer.**
  - `take_action_tracemem_a`: `rd_addr`←`jdo[6:0]`.
  - `take_action_tracemem_b`: the RAM is read at `rd_addr`, then `rd_addr`←`rd_addr`+1, mod 128.
- **Read valid.** The entry is valid iff `trc_wrap`=1 or `rd_addr` < `trc_im_addr`. Both values are sampled in the strobe cycle. `tracemem_tw` takes the valid bit alongside the data.
- **Memory.** Simple dual-port RAM, 1 write and 1 read port, with read-before-write semantics. Memory contents are not reset; stale data is masked by `tracemem_tw`.
- **Simultaneous events.**
  - A clear and a capture in the same cycle: the clear wins, the write is dropped, and `trc_im_addr`=0 next cycle.
  - A tracectrl that turns tracing off in the same cycle as `trc_in_valid`: that word is still captured, because the registered `trc_on` was 1.
  - `take_action_tracemem_a` and `take_action_tracemem_b` in the same cycle: the read uses the old `rd_addr`, and the loaded value wins for the next pointer.
  - A read and a write to the same address in the same cycle: the read returns the old contents.
  - A read in the same cycle as a clear: `tracemem_tw` uses the pre-clear pointers.

## Timing
- **Reset values** (one cycle of `reset` high):
  - `trc_on`, `tracemem_on`, `trc_wrap`, `tracemem_tw` = 0.
  - `trc_im_addr`, `rd_addr` = 0.
  - `tracemem_trcdata` = 0.
- **Reset mid-operation.** Capture aborts immediately, pointers are zeroed, and no write occurs in the reset cycle.
- **Control latency.** A tracectrl strobe in cycle N is visible on `trc_on`, `trc_im_addr` and `trc_wrap` in cycle N+1. The first capture under the new `trc_on` happens in cycle N+1.
- **Capture latency.** A capture in cycle N updates `trc_im_addr` and `trc_wrap` in cycle N+1. The word is readable by a `take_action_tracemem_b` issued in cycle N+1 or later.
- **Read latency.** `take_action_tracemem_b` in cycle N updates `tracemem_trcdata` and `tracemem_tw` in cycle N+1. They hold until the next read strobe or reset.
- **Throughput.** One capture per cycle, sustained. Read strobes may be back-to-back.

## Test plan
- **Reset and idle.** Reset, then 128 idle `trc_in_valid` pulses with `trc_on`=0 -> `trc_im_addr`=0, `trc_wrap`=0, and all outputs stay at 0.
- **Enable, capture, read back.** Tracectrl with `jdo`=0x3, then words 0x0_0000_0001..0x0_0000_0005 -> `trc_im_addr`=5. Read 0..4 via `take_action_tracemem_a`(0) plus 5×`take_action_tracemem_b` -> each returns its word with `tw`=1. A 6th read (addr 5) -> `tw`=0.
- **Wrap, overwrite mode.** 130 captures with data equal to an index 0..129 -> `trc_wrap`=1 after the 128th capture, `trc_im_addr`=2. Reading addr 0 returns 128 and addr 2 returns 2, both with `tw`=1.
- **Stop on full.** `STOP_ON_FULL`=1, 130 captures -> `trc_on` falls the cycle after the 128th capture, `trc_im_addr`=0. Addr 0 holds word 0.
- **Simultaneous clear and capture.** Clear together with `trc_in_valid` at `trc_im_addr`=9 -> next cycle `trc_im_addr`=0, `trc_wrap`=0, and the word is not stored.
- **Reset mid-run.** `reset` during streaming capture at `trc_im_addr`=40 -> next cycle `trc_on`=0 and `trc_im_addr`=0. A subsequent read of addr 0 gives `tw`=0.
